// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// A single full-subtractor cell with a registered borrow, and a start/busy/done handshake.
module serial_subtractor #(
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             Zero,
   output logic             Ovf,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0]    S_IDLE  = 2'd0;
   localparam logic [1:0]    S_SHIFT = 2'd1;
   localparam logic [1:0]    S_DONE  = 2'd2;
   localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d, amsb_q, amsb_d, bmsb_q, bmsb_d;
   logic             bout_q, bout_d, zero_q, zero_d, ovf_q, ovf_d;
   logic             d_bit, br_nxt, accept;
   logic [WIDTH-1:0] r_shift;

   // Full-subtractor cell on the current LSBs and the stored borrow
   assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
   assign br_nxt  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
   assign r_shift = {d_bit, r_q[WIDTH-1:1]};
   assign accept  = start && ((state_q == S_IDLE) || (state_q == S_DONE));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      amsb_d  = amsb_q;
      bmsb_d  = bmsb_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            r_d   = r_shift;
            br_d  = br_nxt;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = S_DONE;
               diff_d  = r_shift;
               bout_d  = br_nxt;
               zero_d  = (r_shift == '0);
               ovf_d   = (amsb_q != bmsb_q) && (r_shift[WIDTH-1] != amsb_q);
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_IDLE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Accepting from DONE as well as IDLE allows back-to-back operations
      if (accept) begin
         state_d = S_SHIFT;
         a_d     = A;
         b_d     = B;
         br_d    = Bin;
         amsb_d  = A[WIDTH-1];
         bmsb_d  = B[WIDTH-1];
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         amsb_q  <= 1'b0;
         bmsb_q  <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         amsb_q  <= amsb_d;
         bmsb_q  <= bmsb_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
      end
   end

   assign Diff = diff_q;
   assign Bout = bout_q;
   assign Zero = zero_q;
   assign Ovf  = ovf_q;
   assign busy = (state_q == S_SHIFT);
   assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH=8): directed vector table, handshake corner cases,
// and random operands checked against an integer-arithmetic reference model.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         Bin = 1'b0;
   logic [W-1:0] Diff;
   logic         Bout, Zero, Ovf, busy, done;

   int errors = 0;
   int checks = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .Bin(Bin),
      .Diff(Diff), .Bout(Bout), .Zero(Zero), .Ovf(Ovf), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] d;
      logic         bo;
      logic         z;
      logic         o;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views of the operands
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output logic [W-1:0] d, output logic bo, output logic z, output logic o);
      int ud, sd;
      ud = int'(a) - int'(b) - int'(bin);
      sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
      d  = W'(ud);
      bo = (ud < 0);
      z  = (d == 0);
      o  = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
   endtask

   // Caller is at a negedge; start is held for one clock, returns at the first busy cycle
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      A = a; B = b; Bin = bin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A = $urandom; B = $urandom; Bin = 1'b0;
   endtask

   // cyc0 = number of the current cycle after accept; returns at the done cycle
   task automatic wait_result(input string nm, input int cyc0, input logic [W-1:0] d,
                              input logic bo, input logic z, input logic o);
      int   cyc;
      logic bok;
      cyc = cyc0;
      bok = 1'b1;
      while (!done && cyc < 40) begin
         if (!busy) bok = 1'b0;
         @(negedge clk);
         cyc++;
      end
      chk({nm, ".latency"}, cyc, W + 1);
      chk({nm, ".busy"}, bok, 1);
      chk({nm, ".done"}, done, 1);
      chk({nm, ".busy_at_done"}, busy, 0);
      chk({nm, ".Diff"}, Diff, d);
      chk({nm, ".Bout"}, Bout, bo);
      chk({nm, ".Zero"}, Zero, z);
      chk({nm, ".Ovf"}, Ovf, o);
   endtask

   initial begin
      logic [W-1:0] ed, ra, rb, hold;
      logic         eb, ez, eo, rbin, saw_done;

      tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
      tbl[5] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};

      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst.Diff", Diff, 0);
      chk("rst.flags", {Bout, Zero, Ovf}, 0);
      chk("rst.busy_done", {busy, done}, 0);

      foreach (tbl[i]) begin
         start_op(tbl[i].a, tbl[i].b, tbl[i].bin);
         wait_result($sformatf("vec%0d", i), 1, tbl[i].d, tbl[i].bo, tbl[i].z, tbl[i].o);
         @(negedge clk);
         chk($sformatf("vec%0d.done_pulse", i), {done, busy}, 0);
         chk($sformatf("vec%0d.hold", i), Diff, tbl[i].d);
      end

      // start during busy is ignored; start during done is accepted back-to-back
      start_op(8'h05, 8'h03, 1'b0);
      repeat (2) @(negedge clk);
      A = 8'h00; B = 8'h00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_result("ignored", 4, 8'h02, 1'b0, 1'b0, 1'b0);
      start_op(8'h09, 8'h01, 1'b0);
      chk("b2b.busy_next", busy, 1);
      wait_result("b2b", 1, 8'h08, 1'b0, 1'b0, 1'b0);

      // reset in the 4th busy cycle aborts without a done pulse
      @(negedge clk);
      start_op(8'h05, 8'h03, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort.Diff", Diff, 0);
      chk("abort.flags", {Bout, Zero, Ovf}, 0);
      chk("abort.busy_done", {busy, done}, 0);
      saw_done = 1'b0;
      repeat (12) begin
         if (done || busy) saw_done = 1'b1;
         @(negedge clk);
      end
      chk("abort.no_done", saw_done, 0);
      start_op(8'h20, 8'h01, 1'b0);
      wait_result("after_rst", 1, 8'h1F, 1'b0, 1'b0, 1'b0);

      // Random operands, mostly back-to-back, with held-output checks in between
      for (int n = 0; n < 150; n++) begin
         ra = $urandom; rb = $urandom; rbin = $urandom_range(0, 1);
         if (n % 10 == 0) rb = ra;
         model(ra, rb, rbin, ed, eb, ez, eo);
         hold = ed;
         start_op(ra, rb, rbin);
         wait_result($sformatf("rnd%0d", n), 1, ed, eb, ez, eo);
         if (n % 3 == 0) begin
            @(negedge clk);
            chk($sformatf("rnd%0d.hold", n), Diff, hold);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
